// File: rtl/color_event_detector.sv
// Colour event detector: debounces a 3-bit colour code and emits one event per new colour
// over a valid/ready handshake. Define COLOR_EVENT_COUNT_EN to enable per-colour counters.
module color_event_detector #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] color_in,
  output logic       event_valid,
  input  logic       event_ready,
  output logic [2:0] event_color,
  output logic [3:0] event_index,
  output logic       event_dropped,
  output logic [7:0] red_cnt,
  output logic [7:0] green_cnt,
  output logic [7:0] blue_cnt
);

  localparam logic [23:0] StableMax = 24'(STABLE_CYCLES);

  typedef enum logic {StIdle, StPend} state_e;

  state_e      state_q, state_d;
  logic [2:0]  prev_color_q;
  logic [23:0] stab_cnt_q, stab_cnt_d;
  logic [2:0]  last_color_q, last_color_d;
  logic [2:0]  color_q, color_d;
  logic [3:0]  index_q, index_d;
  logic        dropped_q, dropped_d;

  logic color_ok, qualified, rearm, gen, handshake;

  always_comb begin
    color_ok = (color_in == 3'b000) || (color_in == 3'b100) ||
               (color_in == 3'b010) || (color_in == 3'b001);
    stab_cnt_d = stab_cnt_q;
    if (!color_ok || (color_in != prev_color_q)) begin
      stab_cnt_d = '0;
    end else if (stab_cnt_q != StableMax) begin
      stab_cnt_d = stab_cnt_q + 24'd1;
    end
  end

  // prev_color holds the colour the stability count refers to, so it is the qualified colour.
  assign qualified = (stab_cnt_q == StableMax);
  assign rearm     = qualified && (prev_color_q == 3'b000);
  assign gen       = qualified && (prev_color_q != 3'b000) && (prev_color_q != last_color_q);
  assign handshake = (state_q == StPend) && event_ready;

  always_comb begin
    last_color_d = last_color_q;
    if (rearm) begin
      last_color_d = 3'b000;
    end else if (gen) begin
      last_color_d = prev_color_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    color_d   = color_q;
    index_d   = index_q;
    dropped_d = dropped_q;
    unique case (state_q)
      StIdle: begin
        if (gen) begin
          state_d = StPend;
          color_d = prev_color_q;
        end
      end
      StPend: begin
        if (handshake) begin
          index_d = index_q + 4'd1;
          if (gen) begin
            color_d = prev_color_q;
          end else begin
            state_d = StIdle;
          end
        end else if (gen) begin
          dropped_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      prev_color_q <= 3'b000;
      stab_cnt_q   <= '0;
      last_color_q <= 3'b000;
      color_q      <= 3'b000;
      index_q      <= 4'd0;
      dropped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_color_q <= color_in;
      stab_cnt_q   <= stab_cnt_d;
      last_color_q <= last_color_d;
      color_q      <= color_d;
      index_q      <= index_d;
      dropped_q    <= dropped_d;
    end
  end

  assign event_valid   = (state_q == StPend);
  assign event_color   = color_q;
  assign event_index   = index_q;
  assign event_dropped = dropped_q;

`ifdef COLOR_EVENT_COUNT_EN
  logic [7:0] red_q, green_q, blue_q;

  // Count the event being accepted, i.e. the colour held before any same-cycle replacement.
  always_ff @(posedge clk) begin
    if (reset) begin
      red_q   <= 8'd0;
      green_q <= 8'd0;
      blue_q  <= 8'd0;
    end else if (handshake) begin
      if (color_q == 3'b100 && red_q != 8'hff)   red_q   <= red_q + 8'd1;
      if (color_q == 3'b010 && green_q != 8'hff) green_q <= green_q + 8'd1;
      if (color_q == 3'b001 && blue_q != 8'hff)  blue_q  <= blue_q + 8'd1;
    end
  end

  assign red_cnt   = red_q;
  assign green_cnt = green_q;
  assign blue_cnt  = blue_q;
`else
  assign red_cnt   = 8'd0;
  assign green_cnt = 8'd0;
  assign blue_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_color_event_detector.sv
// Directed self-checking bench for color_event_detector with STABLE_CYCLES = 4.
module tb_color_event_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] color_in;
  logic       event_ready;
  logic       event_valid;
  logic [2:0] event_color;
  logic [3:0] event_index;
  logic       event_dropped;
  logic [7:0] red_cnt, green_cnt, blue_cnt;

  int vectors = 0;
  int miscompares = 0;

`ifdef COLOR_EVENT_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  color_event_detector #(.STABLE_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .color_in     (color_in),
    .event_valid  (event_valid),
    .event_ready  (event_ready),
    .event_color  (event_color),
    .event_index  (event_index),
    .event_dropped(event_dropped),
    .red_cnt      (red_cnt),
    .green_cnt    (green_cnt),
    .blue_cnt     (blue_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    color_in = 3'b000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Holds a colour for n edges; counts cycles with event_valid and records the last event seen.
  task automatic run_color(input logic [2:0] c, input int n, output int nvalid,
                           output logic [3:0] idx, output logic [2:0] col);
    nvalid = 0;
    idx = 4'hx;
    col = 3'bxxx;
    color_in = c;
    for (int i = 0; i < n; i++) begin
      tick();
      if (event_valid) begin
        nvalid++;
        idx = event_index;
        col = event_color;
      end
    end
  endtask

  int         nv;
  logic [3:0] li;
  logic [2:0] lc;
  int         seen;
  logic [2:0] seq [3];

  initial begin
    seq[0] = 3'b100;
    seq[1] = 3'b010;
    seq[2] = 3'b001;
    event_ready = 1'b0;
    do_reset();
    check("rst_valid", event_valid, 0);
    check("rst_color", event_color, 0);
    check("rst_index", event_index, 0);
    check("rst_dropped", event_dropped, 0);
    check("rst_red", red_cnt, 0);

    // Red from edge 0: valid only after edge 5.
    event_ready = 1'b1;
    color_in = 3'b100;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (event_valid) seen++;
    end
    check("first_early_valid", seen, 0);
    tick();
    check("first_valid", event_valid, 1);
    check("first_color", event_color, 3'b100);
    check("first_index", event_index, 0);
    tick();
    check("first_accepted", event_valid, 0);
    check("first_index_next", event_index, 1);

    // Toggling every 3 cycles never qualifies.
    seen = 0;
    for (int r = 0; r < 4; r++) begin
      run_color(3'b010, 3, nv, li, lc);
      seen += nv;
      run_color(3'b001, 3, nv, li, lc);
      seen += nv;
    end
    check("toggle_no_event", seen, 0);

    // Non-one-hot codes never qualify.
    run_color(3'b110, 10, nv, li, lc);
    check("invalid_no_event", nv, 0);

    // Red, none, red: two events.
    do_reset();
    run_color(3'b100, 7, nv, li, lc);
    check("rearm_ev1_n", nv, 1);
    check("rearm_ev1_idx", li, 0);
    run_color(3'b000, 6, nv, li, lc);
    check("rearm_none_n", nv, 0);
    run_color(3'b100, 7, nv, li, lc);
    check("rearm_ev2_n", nv, 1);
    check("rearm_ev2_idx", li, 1);
    check("rearm_red_cnt", red_cnt, CountEn ? 2 : 0);

    // Drop while pending, then recover.
    do_reset();
    event_ready = 1'b0;
    run_color(3'b100, 7, nv, li, lc);
    check("drop_pending", event_valid, 1);
    run_color(3'b010, 7, nv, li, lc);
    check("drop_flag", event_dropped, 1);
    check("drop_color_held", event_color, 3'b100);
    check("drop_index_held", event_index, 0);
    event_ready = 1'b1;
    run_color(3'b001, 7, nv, li, lc);
    check("drop_blue_n", nv, 1);
    check("drop_blue_color", lc, 3'b001);
    check("drop_blue_idx", li, 1);
    check("drop_sticky", event_dropped, 1);

    // Handshake and new event in the same cycle.
    do_reset();
    event_ready = 1'b0;
    run_color(3'b100, 7, nv, li, lc);
    color_in = 3'b010;
    for (int i = 0; i < 5; i++) tick();
    check("simul_still_red", event_color, 3'b100);
    event_ready = 1'b1;
    tick();
    check("simul_valid", event_valid, 1);
    check("simul_color", event_color, 3'b010);
    check("simul_index", event_index, 1);
    check("simul_no_drop", event_dropped, 0);
    tick();
    check("simul_done", event_valid, 0);
    check("simul_index2", event_index, 2);
    check("simul_red_cnt", red_cnt, CountEn ? 1 : 0);
    check("simul_green_cnt", green_cnt, CountEn ? 1 : 0);

    // 17 accepted events: index wraps 15 -> 0.
    do_reset();
    event_ready = 1'b1;
    for (int e = 0; e < 17; e++) begin
      run_color(seq[e % 3], 7, nv, li, lc);
      check($sformatf("wrap_n%0d", e), nv, 1);
      check($sformatf("wrap_idx%0d", e), li, 32'(e % 16));
    end
    check("wrap_red_cnt", red_cnt, CountEn ? 6 : 0);
    check("wrap_green_cnt", green_cnt, CountEn ? 6 : 0);
    check("wrap_blue_cnt", blue_cnt, CountEn ? 5 : 0);

    // Reset while pending discards the event.
    do_reset();
    event_ready = 1'b0;
    run_color(3'b100, 7, nv, li, lc);
    check("rstpend_pending", event_valid, 1);
    reset = 1'b1;
    event_ready = 1'b1;
    tick();
    reset = 1'b0;
    check("rstpend_valid", event_valid, 0);
    check("rstpend_index", event_index, 0);
    check("rstpend_red", red_cnt, 0);
    tick();
    check("rstpend_no_hs_idx", event_index, 0);
    check("rstpend_no_hs_red", red_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/color_event_detector.md
COLOR_EVENT_DETECTOR -- requirements
Module: color_event_detector

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16 (range 2..2^24-1): consecutive identical cycles of color_in required to qualify a color.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port color_in  input  3  colour code from the colour-sensing stage: 100 red, 010 green, 001 blue, 000 none.
REQ-005 SHALL have port event_valid  output  1  a colour event is pending.
REQ-006 SHALL have port event_ready  input  1  the consumer accepts the event.
REQ-007 SHALL have port event_color  output  3  colour of the pending event (one-hot).
REQ-008 SHALL have port event_index  output  4  sequence number of the pending event.
REQ-009 SHALL have port event_dropped  output  1  sticky flag: a qualified event was lost while one was pending.
REQ-010 SHALL have ports red_cnt, green_cnt, blue_cnt  output  8 each  per-colour accepted-event counts (see Configuration).

Function
REQ-011 SHALL register color_in into prev_color every cycle, and keep a 24-bit stability counter stab_cnt.
REQ-012 SHALL clear stab_cnt to 0 when color_in != prev_color, or when color_in is not one of {000,100,010,001}; otherwise increment stab_cnt, saturating at STABLE_CYCLES.
REQ-013 SHALL treat the colour as qualified in any cycle where stab_cnt == STABLE_CYCLES; with color_in constant from edge k, the colour is first qualified after edge k+STABLE_CYCLES.
REQ-014 SHALL hold last_color (reset 000); on a qualified 000, set last_color to 000 and generate no event (re-arm).
REQ-015 SHALL generate an event on a qualified one-hot colour != last_color; last_color is updated to that colour in the same cycle.
REQ-016 SHALL implement the FSM IDLE -> PEND on event generation, and PEND -> IDLE on event_valid && event_ready.
REQ-017 SHALL drive event_valid high exactly in PEND, registered, one cycle after qualification.
REQ-018 SHALL hold event_color and event_index stable throughout PEND.
REQ-019 SHALL complete a handshake in the first PEND cycle if event_ready is already high; event_ready in IDLE SHALL have no effect.
REQ-020 SHALL set event_dropped and leave the pending event unchanged when a new event would be generated while in PEND; last_color SHALL still update.
REQ-021 SHALL increment event_index on each accepted handshake, wrapping 15 -> 0; the first event SHALL carry index 0.
REQ-022 SHALL, on simultaneous handshake completion and new event generation in the same cycle, accept the old event, stay in PEND with the new colour and index+1, and not set event_dropped.

Reset
REQ-023 SHALL, while reset is high at a clock edge, force: state IDLE, event_valid 0, event_color 000, event_index 0, event_dropped 0, last_color 000, prev_color 000, stab_cnt 0, all colour counters 0.
REQ-024 SHALL, on reset asserted in PEND, discard the pending event with no handshake and no counter update.
REQ-025 SHALL clear event_dropped only by reset.

Configuration
REQ-026 SHALL gate the per-colour counters with the macro COLOR_EVENT_COUNT_EN.
REQ-027 SHALL, with COLOR_EVENT_COUNT_EN defined, increment the counter matching event_color on each accepted handshake, saturating at 255.
REQ-028 SHALL, without COLOR_EVENT_COUNT_EN, keep red_cnt, green_cnt and blue_cnt as ports tied to constant 0 and instantiate no counter flops.

Verification
REQ-029 SHALL cover: STABLE_CYCLES=4, event_ready=1, color_in=100 from edge 0 -> event_valid high for one cycle after edge 5, event_color=100, event_index=0.
REQ-030 SHALL cover: color_in toggling 010/001 every 3 cycles with STABLE_CYCLES=4 -> event_valid never asserts.
REQ-031 SHALL cover: red qualified, then 000 qualified, then red qualified, with event_ready=1 -> two events, indices 0 and 1, red_cnt=2 (macro on).
REQ-032 SHALL cover: event_ready=0, red event pending, then green qualified -> event_dropped=1 and event_color stays 100; after event_ready=1, blue qualified -> event_color=001, index 1.
REQ-033 SHALL cover: 17 accepted events -> index sequence 0..15, 0; with macro off, all *_cnt read 0.
REQ-034 SHALL cover: reset asserted for 1 cycle during PEND -> event_valid=0 next cycle, index 0, counters 0, no handshake.
